// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel servo PWM frame generator with shadowed duty registers; optional per-frame slew limiting when SERVO_SLEW_EN is defined
module servo_pwm_multi #(
    parameter int CLK_HZ    = 25000000,
    parameter int FRAME_HZ  = 50,
    parameter int CHANNELS  = 4,
    parameter int DUTY_W    = 8,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int SLEW_STEP = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   en,
    input  logic                                                   wr,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]     wr_ch,
    input  logic [DUTY_W-1:0]                                      wr_duty,
    output logic [CHANNELS-1:0]                                    pwm,
    output logic                                                   frame_start
);
    localparam int FRAME_CLKS = CLK_HZ / FRAME_HZ;
    localparam int MIN_CLKS   = CLK_HZ / 1000000 * MIN_US;
    localparam int MAX_CLKS   = CLK_HZ / 1000000 * MAX_US;
    localparam int STEP       = (MAX_CLKS - MIN_CLKS) / (2 ** DUTY_W - 1);
    localparam int CNT_W      = $clog2(FRAME_CLKS);
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DUTY_W-1:0] MID  = DUTY_W'(2 ** (DUTY_W - 1));
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(FRAME_CLKS - 1);
`ifdef SERVO_SLEW_EN
    localparam logic [DUTY_W-1:0] SL = DUTY_W'(SLEW_STEP);

    function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] a, input logic [DUTY_W-1:0] t);
        return (t > a) ? ((t - a > SL) ? a + SL : t) : ((a - t > SL) ? a - SL : t);
    endfunction
`endif

    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              run, boundary;
    logic [DUTY_W-1:0] shadow [CHANNELS];
    logic [DUTY_W-1:0] shadow_nx [CHANNELS];
    logic [DUTY_W-1:0] active [CHANNELS];
    logic [DUTY_W-1:0] load [CHANNELS];
    logic [CNT_W-1:0]  wid [CHANNELS];

    // Frame boundary detection, write forwarding into the load path, and per-channel pulse width
    always_comb begin
        boundary = !run || cnt == LAST;
        cnt_nx   = boundary ? '0 : cnt + 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_nx[i] = (wr && wr_ch == CH_W'(i)) ? wr_duty : shadow[i];
`ifdef SERVO_SLEW_EN
            load[i] = boundary ? slew(active[i], shadow_nx[i]) : active[i];
`else
            load[i] = boundary ? shadow_nx[i] : active[i];
`endif
            wid[i] = CNT_W'(MIN_CLKS + int'(load[i]) * STEP);
        end
    end

    // Frame counter, duty registers and registered outputs; active codes only change at a boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            run         <= 1'b0;
            pwm         <= '0;
            frame_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= MID;
                active[i] <= MID;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= shadow_nx[i];
            if (en) begin
                cnt         <= cnt_nx;
                run         <= 1'b1;
                frame_start <= boundary;
                for (int i = 0; i < CHANNELS; i++) begin
                    active[i] <= load[i];
                    pwm[i]    <= cnt_nx < wid[i];
                end
            end else begin
                cnt         <= '0;
                run         <= 1'b0;
                frame_start <= 1'b0;
                pwm         <= '0;
            end
        end
    end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: randomized scoreboard bench for servo_pwm_multi (small frame for fast simulation)
module tb_servo_pwm_multi;
    localparam int CLK_HZ = 1000000, FRAME_HZ = 400, CH = 3, DW = 8, MIN_US = 1000, MAX_US = 2000, SLEW = 4;
    localparam int FRAME = CLK_HZ / FRAME_HZ;
    localparam int MINC  = CLK_HZ / 1000000 * MIN_US;
    localparam int MAXC  = CLK_HZ / 1000000 * MAX_US;
    localparam int STEP  = (MAXC - MINC) / (2 ** DW - 1);
    localparam int MIDC  = 2 ** (DW - 1);

    logic          clk = 0, rst = 1, en = 0, wr = 0;
    logic [1:0]    wr_ch = 0;
    logic [DW-1:0] wr_duty = 0;
    logic [CH-1:0] pwm;
    logic          frame_start;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    servo_pwm_multi #(.CLK_HZ(CLK_HZ), .FRAME_HZ(FRAME_HZ), .CHANNELS(CH), .DUTY_W(DW),
                      .MIN_US(MIN_US), .MAX_US(MAX_US), .SLEW_STEP(SLEW)) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm(pwm), .frame_start(frame_start));

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: duty codes, frame timing and expected high time per finished frame
    int m_sh[CH], m_act[CH], m_w[CH];
    int m_live = 0, m_len = 0;
    bit m_alive = 0, m_open = 0;
    int q_len[$], q_hi[$];

    function automatic int slew_to(input int a, input int t);
`ifdef SERVO_SLEW_EN
        if (t > a) return (t - a > SLEW) ? a + SLEW : t;
        return (a - t > SLEW) ? a - SLEW : t;
`else
        return t;
`endif
    endfunction

    always @(posedge clk) begin
        bit bnd;
        bnd = !rst && en && (!m_alive || m_live == FRAME);
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_sh[i]  = MIDC;
                m_act[i] = MIDC;
            end
        end else if (wr && wr_ch < CH) m_sh[wr_ch] = int'(wr_duty);
        if (bnd) begin
            if (m_open) begin
                q_len.push_back(m_len);
                for (int i = 0; i < CH; i++) q_hi.push_back(m_w[i] < m_live ? m_w[i] : m_live);
            end
            for (int i = 0; i < CH; i++) begin
                m_act[i] = slew_to(m_act[i], m_sh[i]);
                m_w[i]   = MINC + m_act[i] * STEP;
            end
            m_open = 1; m_alive = 1; m_len = 1; m_live = 1;
        end else begin
            if (m_open) m_len++;
            if (m_alive && !rst && en) m_live++;
            else m_alive = 0;
        end
    end

    // Monitor: measure each frame between frame_start pulses and compare against the scoreboard
    int c_len = 0, c_hi[CH];
    bit c_gap[CH], c_split[CH];
    bit c_open = 0;

    always @(negedge clk) begin
        if (frame_start) begin
            if (c_open) begin
                if (q_len.size() == 0) chk("frame_unexpected", 1, 0);
                else begin
                    chk("frame_len", c_len, q_len.pop_front());
                    for (int i = 0; i < CH; i++) begin
                        chk($sformatf("pulse_width_ch%0d", i), c_hi[i], q_hi.pop_front());
                        chk($sformatf("pulse_contig_ch%0d", i), int'(c_split[i]), 0);
                    end
                end
            end
            c_open = 1; c_len = 0;
            for (int i = 0; i < CH; i++) begin
                c_hi[i] = 0; c_gap[i] = 0; c_split[i] = 0;
            end
        end
        if (c_open) begin
            c_len++;
            for (int i = 0; i < CH; i++) begin
                if (pwm[i]) begin
                    c_hi[i]++;
                    if (c_gap[i]) c_split[i] = 1;
                end else c_gap[i] = 1;
            end
        end
    end

    task automatic wr1(input int ch, input int d);
        wr = 1; wr_ch = 2'(ch); wr_duty = DW'(d);
        @(negedge clk);
        wr = 0;
    endtask

    task automatic wait_live(input int v);
        for (int k = 0; k < 3 * FRAME && !(m_alive && m_live == v); k++) @(negedge clk);
    endtask

    // Stimulus: directed corner cases followed by randomized writes and enable drops
    initial begin
        repeat (4) @(negedge clk);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_frame_start", int'(frame_start), 0);
        rst = 0; en = 1;
        repeat (2 * FRAME + 100) @(negedge clk);
        wr1(2, 255);
        wr1(3, $urandom_range(0, 255));
        wait_live(FRAME);
        wr1(0, 0);
        repeat (2 * FRAME) @(negedge clk);
        wait_live(500);
        en = 0;
        @(negedge clk);
        chk("en_drop_pwm", int'(pwm), 0);
        repeat ($urandom_range(3, 20)) @(negedge clk);
        wr1(1, $urandom_range(0, 255));
        en = 1;
        @(negedge clk);
        chk("en_rise_frame_start", int'(frame_start), 1);
        chk("en_rise_pwm", int'(pwm), (1 << CH) - 1);
        wait_live(300);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_pulse_pwm", int'(pwm), 0);
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_release_frame_start", int'(frame_start), 1);
        for (int k = 0; k < 8 * FRAME; k++) begin
            wr = ($urandom_range(0, 299) == 0);
            wr_ch = 2'($urandom_range(0, 3));
            wr_duty = DW'($urandom);
            en = ($urandom_range(0, 2999) != 0);
            @(negedge clk);
        end
        wr = 0; en = 1;
        repeat (2 * FRAME + 10) @(negedge clk);
        chk("scoreboard_drained", q_len.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
